// File: rtl/mul_operand_feeder_if.sv
// Operand-in handshake, multiplier-side bus and status lines of the operand feeder.
// The feeder takes the slave side; whoever supplies operands and the done level takes master.
interface mul_operand_feeder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             mul_start;
   logic [WIDTH-1:0] mul_data;
   logic             mul_done;
   logic             busy;
   logic [7:0]       jobs_done;
   logic             timeout_err;

   modport master (
      output in_valid, in_a, in_b, mul_done,
      input  in_ready, mul_start, mul_data, busy, jobs_done, timeout_err
   );

   modport slave (
      input  in_valid, in_a, in_b, mul_done,
      output in_ready, mul_start, mul_data, busy, jobs_done, timeout_err
   );
endinterface

// File: rtl/mul_operand_feeder.sv
// Buffers operand pairs in a 2-deep FIFO and sequences each pair onto a multiplier:
// start pulse, multiplicand, multiplier, then wait for done or give up after TIMEOUT cycles.
module mul_operand_feeder #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 64
) (
   input logic                 clk,
   input logic                 rst,
   mul_operand_feeder_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } pair_t;

   typedef enum logic [2:0] {IDLE, START, LOAD_A, LOAD_B, WAIT} state_t;

   state_t           state;
   pair_t            fifo [2];
   logic             wr_ptr, rd_ptr;
   logic [1:0]       count;
   logic             push, pop;
   logic [CW-1:0]    wcnt;
   logic             start_q, busy_q, terr_q;
   logic [WIDTH-1:0] data_q;
   logic [7:0]       jobs_q;

   assign push = bus.in_valid && (count != 2'd2);
   // Head leaves on the LOAD_B -> WAIT edge, freeing a slot for the first WAIT cycle.
   assign pop  = (state == LOAD_B);

   always_ff @(posedge clk) begin
      if (push) fifo[wr_ptr] <= '{a: bus.in_a, b: bus.in_b};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wcnt    <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
         jobs_q  <= 8'd0;
         terr_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (count != 2'd0) begin
                  state   <= START;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               state   <= LOAD_A;
               start_q <= 1'b0;
               data_q  <= fifo[rd_ptr].a;
            end
            LOAD_A: begin
               state  <= LOAD_B;
               data_q <= fifo[rd_ptr].b;
            end
            LOAD_B: begin
               state  <= WAIT;
               data_q <= '0;
               wcnt   <= '0;
            end
            WAIT: begin
               // Done is checked first so a completion in the final allowed cycle still counts.
               if (bus.mul_done) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  jobs_q <= jobs_q + 8'd1;
               end else if (wcnt == CW'(TIMEOUT - 1)) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  terr_q <= 1'b1;
               end else begin
                  wcnt <= wcnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               start_q <= 1'b0;
               busy_q  <= 1'b0;
               data_q  <= '0;
            end
         endcase
      end
   end

   assign bus.in_ready    = (count != 2'd2);
   assign bus.mul_start   = start_q;
   assign bus.mul_data    = data_q;
   assign bus.busy        = busy_q;
   assign bus.jobs_done   = jobs_q;
   assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_mul_operand_feeder.sv
// Directed bench for mul_operand_feeder: single job, back-pressure, stale done,
// timeout and its boundary, reset mid-job, and jobs_done wrap.
module tb_mul_operand_feeder;
   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   mul_operand_feeder_if #(.WIDTH(WIDTH)) bus ();

   mul_operand_feeder #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.mul_done = 1'b0;
      steps(2);
      rst = 1'b0;
   endtask

   // Offers a pair and returns just after the edge that accepted it.
   task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      bit ok = 0;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         ok = bus.in_ready;
         step();
      end
      bus.in_valid = 1'b0;
      if (!ok) chk("push_timeout", 0, 1);
   endtask

   initial begin
      bit seen_start;
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.mul_done = 1'b0;

      // Reset state
      do_reset();
      chk("rst_busy", bus.busy, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_mul_start", bus.mul_start, 0);
      chk("rst_mul_data", bus.mul_data, 0);
      chk("rst_jobs", bus.jobs_done, 0);
      chk("rst_terr", bus.timeout_err, 0);

      // Single job (17,5)
      push(16'd17, 16'd5);
      chk("s_idle_start", bus.mul_start, 0);
      step();
      chk("s_start", bus.mul_start, 1);
      chk("s_start_busy", bus.busy, 1);
      chk("s_start_data", bus.mul_data, 0);
      step();
      chk("s_start_low", bus.mul_start, 0);
      chk("s_data_a", bus.mul_data, 17);
      step();
      chk("s_data_b", bus.mul_data, 5);
      step();
      chk("s_wait_data", bus.mul_data, 0);
      chk("s_wait_busy", bus.busy, 1);
      bus.mul_done = 1'b1;
      step();
      bus.mul_done = 1'b0;
      chk("s_done_busy", bus.busy, 0);
      chk("s_jobs", bus.jobs_done, 1);

      // Back-pressure with three pairs
      do_reset();
      push(16'd3, 16'd4);
      push(16'd6, 16'd7);
      chk("bp_full", bus.in_ready, 0);
      chk("bp_start1", bus.mul_start, 1);
      bus.in_a = 16'd8;
      bus.in_b = 16'd9;
      bus.in_valid = 1'b1;
      step();
      chk("bp_a1", bus.mul_data, 3);
      chk("bp_full_la", bus.in_ready, 0);
      step();
      chk("bp_b1", bus.mul_data, 4);
      chk("bp_full_lb", bus.in_ready, 0);
      step();
      chk("bp_ready_wait", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      chk("bp_full_again", bus.in_ready, 0);
      bus.mul_done = 1'b1;
      step();
      chk("bp_idle_gap", bus.busy, 0);
      chk("bp_jobs1", bus.jobs_done, 1);
      step();
      chk("bp_start2", bus.mul_start, 1);
      step();
      chk("bp_a2", bus.mul_data, 6);
      step();
      chk("bp_b2", bus.mul_data, 7);
      steps(2);
      chk("bp_jobs2", bus.jobs_done, 2);
      step();
      chk("bp_start3", bus.mul_start, 1);
      step();
      chk("bp_a3", bus.mul_data, 8);
      step();
      chk("bp_b3", bus.mul_data, 9);
      steps(2);
      chk("bp_jobs3", bus.jobs_done, 3);
      chk("bp_end_busy", bus.busy, 0);

      // Stale done held high throughout
      do_reset();
      bus.mul_done = 1'b1;
      push(16'd2, 16'd2);
      step();
      chk("sd_start", bus.mul_start, 1);
      step();
      chk("sd_a", bus.mul_data, 2);
      chk("sd_jobs_la", bus.jobs_done, 0);
      step();
      chk("sd_b", bus.mul_data, 2);
      step();
      chk("sd_wait_busy", bus.busy, 1);
      chk("sd_jobs_wait", bus.jobs_done, 0);
      step();
      chk("sd_done_busy", bus.busy, 0);
      chk("sd_jobs", bus.jobs_done, 1);
      bus.mul_done = 1'b0;

      // Timeout, then a completing job
      do_reset();
      push(16'd9, 16'd1);
      steps(4);
      chk("to_wait1", bus.busy, 1);
      steps(63);
      chk("to_wait64_busy", bus.busy, 1);
      chk("to_wait64_terr", bus.timeout_err, 0);
      step();
      chk("to_idle", bus.busy, 0);
      chk("to_terr", bus.timeout_err, 1);
      chk("to_jobs", bus.jobs_done, 0);
      bus.mul_done = 1'b1;
      push(16'd2, 16'd3);
      steps(5);
      chk("to_next_jobs", bus.jobs_done, 1);
      chk("to_next_terr", bus.timeout_err, 1);
      bus.mul_done = 1'b0;

      // Done in the last allowed WAIT cycle beats the timeout
      do_reset();
      push(16'd4, 16'd4);
      steps(67);
      chk("tb_last_busy", bus.busy, 1);
      bus.mul_done = 1'b1;
      step();
      bus.mul_done = 1'b0;
      chk("tb_busy", bus.busy, 0);
      chk("tb_jobs", bus.jobs_done, 1);
      chk("tb_terr", bus.timeout_err, 0);

      // Reset during LOAD_A with two pairs queued
      do_reset();
      push(16'd1, 16'd2);
      push(16'd3, 16'd4);
      step();
      chk("rm_load_a", bus.mul_data, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rm_busy", bus.busy, 0);
      chk("rm_ready", bus.in_ready, 1);
      chk("rm_data", bus.mul_data, 0);
      chk("rm_jobs", bus.jobs_done, 0);
      seen_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.mul_start) seen_start = 1'b1;
      end
      chk("rm_no_start", seen_start, 0);

      // jobs_done wrap at 256
      do_reset();
      bus.mul_done = 1'b1;
      for (int i = 0; i < 255; i++) push(16'(i), 16'(i + 1));
      steps(12);
      chk("wrap_255", bus.jobs_done, 255);
      push(16'd7, 16'd7);
      steps(6);
      chk("wrap_0", bus.jobs_done, 0);
      chk("wrap_busy", bus.busy, 0);
      bus.mul_done = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule

// File: doc/mul_operand_feeder.md
MUL_OPERAND_FEEDER -- requirements
Module: mul_operand_feeder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand and bus width.
REQ-002 The block SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles allowed before the job is abandoned.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  meaning the reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid  input  1  meaning an operand pair is offered.
REQ-006 The block SHALL have port in_ready  output  1  meaning the block can accept a pair.
REQ-007 The block SHALL have port in_a  input  WIDTH  meaning the multiplicand.
REQ-008 The block SHALL have port in_b  input  WIDTH  meaning the multiplier.
REQ-009 The block SHALL have port mul_start  output  1  meaning the start pulse to the multiplier controller.
REQ-010 The block SHALL have port mul_data  output  WIDTH  meaning the multiplier data_in bus.
REQ-011 The block SHALL have port mul_done  input  1  meaning the multiplier completion level.
REQ-012 The block SHALL have port busy  output  1  meaning a job is in flight.
REQ-013 The block SHALL have port jobs_done  output  8  meaning the count of completed jobs.
REQ-014 The block SHALL have port timeout_err  output  1  meaning a sticky flag, set when a job timed out.

Function
REQ-015 The block SHALL accept a pair on a rising edge where in_valid=1 and in_ready=1, writing {in_a,in_b} into a 2-entry FIFO.
REQ-016 in_ready SHALL equal "FIFO not full"; when the FIFO is full, in_valid SHALL be ignored and no entry overwritten.
REQ-017 The FSM SHALL have states IDLE, START, LOAD_A, LOAD_B, WAIT.
REQ-018 IDLE -> START SHALL occur on the first edge on which the FIFO is non-empty; a pair written at edge k gives START during cycle k+1 (no bypass).
REQ-019 In START, mul_start SHALL be 1 for exactly that one cycle; mul_start SHALL be 0 in all other states.
REQ-020 START -> LOAD_A -> LOAD_B -> WAIT SHALL be unconditional single-cycle steps.
REQ-021 In LOAD_A, mul_data SHALL equal the head in_a; in LOAD_B, it SHALL equal the head in_b; in all other states, mul_data SHALL be 0.
REQ-022 The head entry SHALL be popped on the LOAD_B -> WAIT edge, so in_ready can rise in the first WAIT cycle.
REQ-023 A push and a pop on the same edge SHALL both take effect, leaving the occupancy unchanged.
REQ-024 mul_done SHALL be ignored in IDLE, START, LOAD_A and LOAD_B, since a stale done from the previous job is masked.
REQ-025 In WAIT, mul_done=1 SHALL cause WAIT -> IDLE and increment jobs_done on that edge; jobs_done SHALL wrap from 255 to 0.
REQ-026 The WAIT cycle counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-027 If mul_done=1 has not been seen within TIMEOUT WAIT cycles, the FSM SHALL go WAIT -> IDLE, set timeout_err, and leave jobs_done unchanged.
REQ-028 If mul_done=1 arrives on the same edge the counter reaches TIMEOUT, completion SHALL win and no timeout is flagged.
REQ-029 busy SHALL be 1 in START, LOAD_A, LOAD_B and WAIT, and 0 in IDLE.
REQ-030 After WAIT -> IDLE with the FIFO non-empty, the next START SHALL occur in the following cycle, giving exactly one IDLE cycle between jobs.

Reset
REQ-031 When rst=1 at an edge, the block SHALL enter IDLE, empty the FIFO, and clear the WAIT counter, jobs_done and timeout_err.
REQ-032 After reset, the block SHALL drive mul_start=0, mul_data=0, busy=0 and in_ready=1.
REQ-033 Reset asserted mid-job, in any state, SHALL abandon the job and discard both FIFO entries without incrementing jobs_done.
REQ-034 rst SHALL take priority over all push, pop and FSM transitions on the same edge.

Verification
REQ-035 Single job: push (17,5) at edge k -> mul_start=1 in cycle k+1, mul_data=17 in k+2, mul_data=5 in k+3; mul_done=1 in WAIT -> jobs_done=1, busy=0.
REQ-036 Back-pressure: push (3,4),(6,7),(8,9) back-to-back while idle -> in_ready=0 after 2 pushes; third accepted only after the first LOAD_B; three jobs issued in order with mul_data 3,4 / 6,7 / 8,9.
REQ-037 Stale done: hold mul_done=1 continuously, push (2,2) -> job still sequences START/LOAD_A/LOAD_B and completes on the first WAIT cycle; jobs_done=1.
REQ-038 Timeout: TIMEOUT=64, push (9,1), never assert mul_done -> after 64 WAIT cycles state returns to IDLE, timeout_err=1, jobs_done=0; a following job (2,3) with done completes with timeout_err still 1.
REQ-039 Reset mid-job: 2 pairs queued, rst=1 during LOAD_A -> next cycle busy=0, in_ready=1, mul_data=0, jobs_done=0, and no further mul_start.
REQ-040 Wrap: complete 256 jobs -> jobs_done reads 0.
